// File: rtl/pe_packet_dispatcher.sv
// Transmit side of the PE broadcast bus: reads 4-element buffer words and tags each with a packet_idx.
// Optional build macro DISPATCH_STALL_CNT_EN adds a saturating stall_cycles counter output.
//
// state | meaning
// IDLE  | waiting for start
// READ  | buffer read strobe for packet k
// WAIT  | capture read data into the held packet
// SEND  | offer packet; held while the target slot is busy
// FIN   | done pulse, then back to IDLE
module pe_packet_dispatcher #(
    parameter int ADDR_W      = 12,
    parameter int NPKT_W      = 10,
    parameter int IDX_SLOTS   = 32,
    parameter int IFDATA_SIZE = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       op_stage,
    input  logic [ADDR_W-1:0]          cfg_base_addr,
    input  logic [NPKT_W-1:0]          cfg_num_pkts,
    input  logic [2:0]                 cfg_rows,
    input  logic [4:0]                 cfg_idx_span,
    input  logic [IDX_SLOTS-1:0]       idx_busy,
    output logic                       buf_rd_en,
    output logic [ADDR_W-1:0]          buf_rd_addr,
    input  logic [4*IFDATA_SIZE-1:0]   buf_rd_data,
    output logic [4*IFDATA_SIZE+5:0]   pe_packet,
    output logic                       busy,
    output logic                       done,
    output logic                       err
`ifdef DISPATCH_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cycles
`endif
);

    // op_stage encoding: 0 = LOAD_FILTER, 1 = CONV
    localparam logic OP_CONV = 1'b1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;

    state_t                   state, state_d;
    logic                     op_q;
    logic [2:0]               rows_q;
    logic [4:0]               span_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [NPKT_W-1:0]        left_q;
    logic [2:0]               row_q;
    logic [1:0]               filt_q;
    logic [4:0]               conv_q;
    logic [4*IFDATA_SIZE-1:0] data_q;

    logic [4:0] cur_idx;
    logic       slot_busy;
    logic       send_fire;
    logic       start_acc;

    assign cur_idx   = (op_q == OP_CONV) ? conv_q : {filt_q, row_q};
    assign slot_busy = idx_busy[cur_idx];
    assign send_fire = (state == SEND) && !slot_busy && !abort;
    assign start_acc = (state == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d     = state;
        buf_rd_en   = 1'b0;
        buf_rd_addr = addr_q;
        done        = 1'b0;
        busy        = (state != IDLE);
        err         = start && (state != IDLE) && !abort;
        pe_packet   = {send_fire, cur_idx, data_q};
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_d = (cfg_num_pkts == '0) ? FIN : READ;
                READ: begin
                    buf_rd_en = 1'b1;
                    state_d   = WAIT;
                end
                WAIT: state_d = SEND;
                SEND: if (!slot_busy) state_d = (left_q == NPKT_W'(1)) ? FIN : READ;
                FIN: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // CONV span of 0 behaves as 32: span-1 wraps to 31 in 5 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 1'b0;
            rows_q <= '0;
            span_q <= '0;
            addr_q <= '0;
            left_q <= '0;
            row_q  <= '0;
            filt_q <= '0;
            conv_q <= '0;
            data_q <= '0;
        end else if (abort) begin
            addr_q <= '0;
            left_q <= '0;
            row_q  <= '0;
            filt_q <= '0;
            conv_q <= '0;
            data_q <= '0;
        end else if (start_acc) begin
            op_q   <= op_stage;
            rows_q <= cfg_rows;
            span_q <= cfg_idx_span;
            addr_q <= cfg_base_addr;
            left_q <= cfg_num_pkts;
            row_q  <= '0;
            filt_q <= '0;
            conv_q <= '0;
        end else begin
            if (state == WAIT) data_q <= buf_rd_data;
            if (send_fire) begin
                addr_q <= addr_q + ADDR_W'(1);
                left_q <= left_q - NPKT_W'(1);
                if (row_q == rows_q - 3'd1) begin
                    row_q  <= '0;
                    filt_q <= filt_q + 2'd1;
                end else begin
                    row_q <= row_q + 3'd1;
                end
                if (conv_q == span_q - 5'd1) conv_q <= '0;
                else                         conv_q <= conv_q + 5'd1;
            end
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (start_acc)
            stall_cycles <= '0;
        else if ((state == SEND) && slot_busy && !abort && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pe_packet_dispatcher.sv
// Directed bench for pe_packet_dispatcher; cycle 0 is the cycle in which start is sampled.
module tb_pe_packet_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, op_stage;
    logic [11:0] cfg_base_addr;
    logic [9:0]  cfg_num_pkts;
    logic [2:0]  cfg_rows;
    logic [4:0]  cfg_idx_span;
    logic [31:0] idx_busy;
    logic        buf_rd_en;
    logic [11:0] buf_rd_addr;
    logic [31:0] buf_rd_data;
    logic [37:0] pe_packet;
    logic        busy, done, err;
`ifdef DISPATCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic        v_log    [0:63];
    logic [4:0]  idx_log  [0:63];
    logic [31:0] data_log [0:63];
    logic        rd_log   [0:63];
    logic [11:0] addr_log [0:63];
    logic        done_log [0:63];
    logic        busy_log [0:63];
    logic        err_log  [0:63];

    int lf_idx [8] = '{0, 1, 2, 8, 9, 10, 16, 17};

    pe_packet_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_stage(op_stage),
        .cfg_base_addr(cfg_base_addr), .cfg_num_pkts(cfg_num_pkts), .cfg_rows(cfg_rows),
        .cfg_idx_span(cfg_idx_span), .idx_busy(idx_busy), .buf_rd_en(buf_rd_en),
        .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .pe_packet(pe_packet),
        .busy(busy), .done(done), .err(err)
`ifdef DISPATCH_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [11:0] a);
        return {~a[7:0], a[11:4], a[3:0], 4'h5, a[7:0]};
    endfunction

    always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem(buf_rd_addr);

    // Entered just after a rising edge; drives cycle c and logs outputs at the falling edge.
    task automatic run_burst(input int ncyc, input int bfrom, input int bto,
                             input logic [31:0] bmask, input int abort_c, input int restart_c);
        for (int c = 0; c < ncyc; c++) begin
            start    = (c == 0) || (c == restart_c);
            abort    = (c == abort_c);
            idx_busy = (c >= bfrom && c <= bto) ? bmask : 32'h0;
            @(negedge clk);
            v_log[c]    = pe_packet[37];
            idx_log[c]  = pe_packet[36:32];
            data_log[c] = pe_packet[31:0];
            rd_log[c]   = buf_rd_en;
            addr_log[c] = buf_rd_addr;
            done_log[c] = done;
            busy_log[c] = busy;
            err_log[c]  = err;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; idx_busy = 32'h0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (pe_packet !== 38'h0) begin n_fail++; $display("FAIL reset_pkt got %h exp 0", pe_packet); end
        n_checks++;
        if ({busy, done, err, buf_rd_en} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0000", {busy, done, err, buf_rd_en});
        end
        n_checks++;
        if (buf_rd_addr !== 12'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", buf_rd_addr); end
    endtask

    task automatic test_conv();
        logic ev, er;
        int i;
        op_stage = 1'b1; cfg_base_addr = 12'h010; cfg_num_pkts = 10'd3; cfg_idx_span = 5'd2; cfg_rows = 3'd1;
        run_burst(13, -1, -1, 32'h0, -1, -1);
        for (int c = 0; c < 13; c++) begin
            ev = (c == 3 || c == 6 || c == 9);
            er = (c == 1 || c == 4 || c == 7);
            i  = (c - 1) / 3;
            n_checks++;
            if (v_log[c] !== ev) begin n_fail++; $display("FAIL conv_valid c%0d got %b exp %b", c, v_log[c], ev); end
            n_checks++;
            if (rd_log[c] !== er) begin n_fail++; $display("FAIL conv_rd c%0d got %b exp %b", c, rd_log[c], er); end
            n_checks++;
            if (done_log[c] !== (c == 10)) begin n_fail++; $display("FAIL conv_done c%0d got %b", c, done_log[c]); end
            n_checks++;
            if (busy_log[c] !== (c >= 1 && c <= 10)) begin n_fail++; $display("FAIL conv_busy c%0d got %b", c, busy_log[c]); end
            if (er) begin
                n_checks++;
                if (addr_log[c] !== 12'h010 + 12'(i)) begin
                    n_fail++; $display("FAIL conv_addr c%0d got %h exp %h", c, addr_log[c], 12'h010 + 12'(i));
                end
            end
            if (ev) begin
                n_checks++;
                if (idx_log[c] !== 5'(i % 2)) begin n_fail++; $display("FAIL conv_idx c%0d got %0d exp %0d", c, idx_log[c], i % 2); end
                n_checks++;
                if (data_log[c] !== mem(12'h010 + 12'(i))) begin
                    n_fail++; $display("FAIL conv_data c%0d got %h exp %h", c, data_log[c], mem(12'h010 + 12'(i)));
                end
            end
        end
    endtask

    task automatic test_load_filter();
        logic ev;
        int i;
        logic [11:0] ea;
        op_stage = 1'b0; cfg_base_addr = 12'hFFE; cfg_num_pkts = 10'd8; cfg_rows = 3'd3; cfg_idx_span = 5'd7;
        run_burst(27, -1, -1, 32'h0, -1, -1);
        for (int c = 0; c < 27; c++) begin
            i  = (c - 3) / 3;
            ev = (c >= 3) && ((c % 3) == 0) && (i < 8);
            ea = 12'hFFE + 12'(i);
            n_checks++;
            if (v_log[c] !== ev) begin n_fail++; $display("FAIL lf_valid c%0d got %b exp %b", c, v_log[c], ev); end
            n_checks++;
            if (done_log[c] !== (c == 25)) begin n_fail++; $display("FAIL lf_done c%0d got %b", c, done_log[c]); end
            if (ev) begin
                n_checks++;
                if (idx_log[c] !== 5'(lf_idx[i])) begin
                    n_fail++; $display("FAIL lf_idx c%0d got %0d exp %0d", c, idx_log[c], lf_idx[i]);
                end
                n_checks++;
                if (data_log[c] !== mem(ea)) begin n_fail++; $display("FAIL lf_data c%0d got %h exp %h", c, data_log[c], mem(ea)); end
                n_checks++;
                if (addr_log[c-2] !== ea || rd_log[c-2] !== 1'b1) begin
                    n_fail++; $display("FAIL lf_addr c%0d got %h/%b exp %h/1", c - 2, addr_log[c-2], rd_log[c-2], ea);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic ev;
        op_stage = 1'b1; cfg_base_addr = 12'h020; cfg_num_pkts = 10'd3; cfg_idx_span = 5'd4; cfg_rows = 3'd1;
        run_burst(17, 6, 10, 32'h0000_0002, -1, -1);
        for (int c = 0; c < 17; c++) begin
            ev = (c == 3 || c == 11 || c == 14);
            n_checks++;
            if (v_log[c] !== ev) begin n_fail++; $display("FAIL stall_valid c%0d got %b exp %b", c, v_log[c], ev); end
            if (c >= 6 && c <= 11) begin
                n_checks++;
                if (data_log[c] !== mem(12'h021) || idx_log[c] !== 5'd1) begin
                    n_fail++; $display("FAIL stall_hold c%0d got %h/%0d exp %h/1", c, data_log[c], idx_log[c], mem(12'h021));
                end
            end
        end
        n_checks++;
        if (idx_log[14] !== 5'd2 || data_log[14] !== mem(12'h022)) begin
            n_fail++; $display("FAIL stall_third got %0d/%h exp 2/%h", idx_log[14], data_log[14], mem(12'h022));
        end
        n_checks++;
        if (done_log[15] !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b exp 1", done_log[15]); end
`ifdef DISPATCH_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 16'd5) begin n_fail++; $display("FAIL stall_cnt got %0d exp 5", stall_cycles); end
`endif
    endtask

    task automatic test_zero_pkts();
        op_stage = 1'b1; cfg_base_addr = 12'h100; cfg_num_pkts = 10'd0; cfg_idx_span = 5'd2;
        run_burst(5, -1, -1, 32'h0, -1, -1);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rd_log[c] !== 1'b0 || v_log[c] !== 1'b0) begin
                n_fail++; $display("FAIL zero_rd c%0d got %b/%b exp 0/0", c, rd_log[c], v_log[c]);
            end
            n_checks++;
            if (done_log[c] !== (c == 1) || busy_log[c] !== (c == 1)) begin
                n_fail++; $display("FAIL zero_done c%0d got %b/%b exp %b", c, done_log[c], busy_log[c], c == 1);
            end
        end
    endtask

    task automatic test_restart();
        logic ev;
        int i;
        op_stage = 1'b1; cfg_base_addr = 12'h010; cfg_num_pkts = 10'd3; cfg_idx_span = 5'd2;
        run_burst(13, -1, -1, 32'h0, -1, 5);
        for (int c = 0; c < 13; c++) begin
            ev = (c == 3 || c == 6 || c == 9);
            i  = (c - 3) / 3;
            n_checks++;
            if (err_log[c] !== (c == 5)) begin n_fail++; $display("FAIL restart_err c%0d got %b exp %b", c, err_log[c], c == 5); end
            n_checks++;
            if (v_log[c] !== ev) begin n_fail++; $display("FAIL restart_valid c%0d got %b exp %b", c, v_log[c], ev); end
            if (ev) begin
                n_checks++;
                if (idx_log[c] !== 5'(i % 2) || data_log[c] !== mem(12'h010 + 12'(i))) begin
                    n_fail++; $display("FAIL restart_pkt c%0d got %0d/%h exp %0d/%h", c, idx_log[c], data_log[c], i % 2, mem(12'h010 + 12'(i)));
                end
            end
        end
        n_checks++;
        if (done_log[10] !== 1'b1) begin n_fail++; $display("FAIL restart_done got %b exp 1", done_log[10]); end
    endtask

    task automatic test_abort();
        op_stage = 1'b1; cfg_base_addr = 12'h040; cfg_num_pkts = 10'd3; cfg_idx_span = 5'd2;
        run_burst(12, 6, 9, 32'h0000_0002, 7, -1);
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if (v_log[c] !== (c == 3)) begin n_fail++; $display("FAIL abort_valid c%0d got %b exp %b", c, v_log[c], c == 3); end
            n_checks++;
            if (done_log[c] !== 1'b0) begin n_fail++; $display("FAIL abort_done c%0d got %b exp 0", c, done_log[c]); end
        end
        n_checks++;
        if (busy_log[8] !== 1'b0 || busy_log[7] !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle got %b%b exp 10", busy_log[7], busy_log[8]);
        end
        cfg_base_addr = 12'h030; cfg_num_pkts = 10'd1;
        run_burst(6, -1, -1, 32'h0, -1, -1);
        n_checks++;
        if (v_log[3] !== 1'b1 || idx_log[3] !== 5'd0 || data_log[3] !== mem(12'h030)) begin
            n_fail++; $display("FAIL abort_fresh got %b/%0d/%h exp 1/0/%h", v_log[3], idx_log[3], data_log[3], mem(12'h030));
        end
        n_checks++;
        if (done_log[4] !== 1'b1) begin n_fail++; $display("FAIL abort_fresh_done got %b exp 1", done_log[4]); end
    endtask

    task automatic test_midburst_reset();
        op_stage = 1'b1; cfg_base_addr = 12'h050; cfg_num_pkts = 10'd4; cfg_idx_span = 5'd3;
        run_burst(4, -1, -1, 32'h0, -1, -1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || pe_packet !== 38'h0 || buf_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL midreset got busy %b pkt %h rd %b exp 0", busy, pe_packet, buf_rd_en);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_stage = 1'b0;
        cfg_base_addr = '0; cfg_num_pkts = '0; cfg_rows = 3'd1; cfg_idx_span = 5'd1;
        idx_busy = '0; buf_rd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_conv();
        test_load_filter();
        test_stall();
        test_zero_pkts();
        test_restart();
        test_abort();
        test_midburst_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
